commit_stage_reg: RTL and testbench

Parametrised pipeline stage register for the commit-trace bundle (commit flag, pre-PC, instruction, PC), carrying up to LANES retiring instructions per cycle between adjacent pipeline stages. Adds a valid/ready handshake, an optional two-entry skid buffer for full-throughput back-pressure, a synchronous flush and a retired-instruction counter. It is the drop-in successor for the fixed single-lane D→E commit register and is instantiated at every stage boundary that forwards commit information toward the difftest/commit port.

---
 rtl/commit_stage_reg.sv | 179 +++++++++++++++++
 tb/tb_commit_stage_reg.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_stage_reg.sv
// commit_stage_reg: pipeline register for the commit-trace bundle
// (commit flag, pre-PC, instruction, PC) carrying up to LANES retiring
// instructions per beat. Valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a running count of committed lanes.
`timescale 1ns/1ps
module commit_stage_reg #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int LANES = 1,
    parameter int SKID  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_commit,
    input  logic [LANES*XLEN-1:0] in_pre_pc,
    input  logic [LANES*ILEN-1:0] in_instr,
    input  logic [LANES*XLEN-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_commit,
    output logic [LANES*XLEN-1:0] out_pre_pc,
    output logic [LANES*ILEN-1:0] out_instr,
    output logic [LANES*XLEN-1:0] out_pc,
    output logic [63:0]           commit_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_deliver;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid;

    logic [LANES-1:0]      r_main_commit;
    logic [LANES*XLEN-1:0] r_main_pre_pc;
    logic [LANES*ILEN-1:0] r_main_instr;
    logic [LANES*XLEN-1:0] r_main_pc;

    logic [LANES-1:0]      r_skid_commit;
    logic [LANES*XLEN-1:0] r_skid_pre_pc;
    logic [LANES*ILEN-1:0] r_skid_instr;
    logic [LANES*XLEN-1:0] r_skid_pc;

    logic [63:0]           r_commit_cnt;

    // Number of committed lanes in one beat, widened to counter size.
    function automatic logic [63:0] f_popcount(input logic [LANES-1:0] v);
        logic [63:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + 64'(v[i]);
        end
        return n;
    endfunction

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_deliver = out_valid & out_ready;

    // Main entry valid means a beat is presented; commit flags are masked
    // so an idle output never looks like a retirement.
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_commit = r_main_commit & {LANES{out_valid}};
    assign out_pre_pc = r_main_pre_pc;
    assign out_instr  = r_main_instr;
    assign out_pc     = r_main_pc;
    assign commit_cnt = r_commit_cnt;

    // Ready: registered from next occupancy with the skid buffer (no path
    // from out_ready), combinational pass-through ready without it.
    generate
        if (SKID != 0) begin : g_skid_ready
            logic r_in_ready;
            // in_ready is high whenever the skid entry will be free next cycle
            always_ff @(posedge clk) begin
                if (!rst) r_in_ready <= 1'b1;
                else      r_in_ready <= (w_state_nxt != ST_FULL);
            end
            assign in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_EMPTY;
        else      r_state <= w_state_nxt;
    end

    // Next occupancy and entry load strobes; flush empties everything and
    // suppresses loads so the payload keeps its last value.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_deliver) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_deliver) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_deliver) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Main entry payload: loaded from the input or promoted from skid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_commit <= '0;
            r_main_pre_pc <= '0;
            r_main_instr  <= '0;
            r_main_pc     <= '0;
        end else if (w_load_main_in) begin
            r_main_commit <= in_commit;
            r_main_pre_pc <= in_pre_pc;
            r_main_instr  <= in_instr;
            r_main_pc     <= in_pc;
        end else if (w_load_main_skid) begin
            r_main_commit <= r_skid_commit;
            r_main_pre_pc <= r_skid_pre_pc;
            r_main_instr  <= r_skid_instr;
            r_main_pc     <= r_skid_pc;
        end
    end

    // Skid entry payload: absorbs the beat accepted while main is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skid_commit <= '0;
            r_skid_pre_pc <= '0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
        end else if (w_load_skid) begin
            r_skid_commit <= in_commit;
            r_skid_pre_pc <= in_pre_pc;
            r_skid_instr  <= in_instr;
            r_skid_pc     <= in_pc;
        end
    end

    // Retired-lane counter: counts every delivered beat, flush or not
    always_ff @(posedge clk) begin
        if (!rst)           r_commit_cnt <= '0;
        else if (w_deliver) r_commit_cnt <= r_commit_cnt + f_popcount(out_commit);
    end

endmodule

// File: tb/tb_commit_stage_reg.sv
// Scoreboard bench for commit_stage_reg: a 4-lane skid instance and a
// 1-lane pass-through instance, directed beats with hand-derived results.
`timescale 1ns/1ps
module tb_commit_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 4-lane, skid-buffered instance
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]   a_in_commit, a_out_commit;
    logic [255:0] a_in_pre_pc, a_in_pc, a_out_pre_pc, a_out_pc;
    logic [127:0] a_in_instr, a_out_instr;
    logic [63:0]  a_cnt;

    // 1-lane, combinational-ready instance
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]   b_in_commit, b_out_commit;
    logic [63:0]  b_in_pre_pc, b_in_pc, b_out_pre_pc, b_out_pc;
    logic [31:0]  b_in_instr, b_out_instr;
    logic [63:0]  b_cnt;

    commit_stage_reg #(.XLEN(64), .ILEN(32), .LANES(4), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_commit(a_in_commit), .in_pre_pc(a_in_pre_pc), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_commit(a_out_commit), .out_pre_pc(a_out_pre_pc), .out_instr(a_out_instr), .out_pc(a_out_pc),
        .commit_cnt(a_cnt)
    );

    commit_stage_reg #(.XLEN(64), .ILEN(32), .LANES(1), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_commit(b_in_commit), .in_pre_pc(b_in_pre_pc), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_commit(b_out_commit), .out_pre_pc(b_out_pre_pc), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .commit_cnt(b_cnt)
    );

    typedef struct {
        logic [3:0]   c;
        logic [255:0] pre;
        logic [127:0] ins;
        logic [255:0] pc;
    } beat_t;

    beat_t a_q[$];
    beat_t b_q[$];
    beat_t a_e, b_e;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Beat k: lane i PC = 0x8000_0000 + 8k + 4i, pre-PC = PC - 4
    function automatic beat_t mk(input int k, input logic [3:0] c);
        beat_t b;
        b.c = c;
        for (int i = 0; i < 4; i++) begin
            b.pc[i*64 +: 64]  = 64'h8000_0000 + 64'(8 * k) + 64'(4 * i);
            b.pre[i*64 +: 64] = 64'h8000_0000 + 64'(8 * k) + 64'(4 * i) - 64'd4;
            b.ins[i*32 +: 32] = 32'h0000_0013 + 32'(k * 256 + i * 16);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input beat_t b);
        a_in_commit = b.c;
        a_in_pre_pc = b.pre;
        a_in_instr  = b.ins;
        a_in_pc     = b.pc;
        a_in_valid  = 1'b1;
    endtask

    task automatic b_drive(input beat_t b);
        b_in_commit = b.c[0:0];
        b_in_pre_pc = b.pre[63:0];
        b_in_instr  = b.ins[31:0];
        b_in_pc     = b.pc[63:0];
        b_in_valid  = 1'b1;
    endtask

    // Hold a beat on the A input until the stage takes it (bounded)
    task automatic a_offer(input beat_t b);
        bit done;
        done = 1'b0;
        a_drive(b);
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (a_in_ready && !a_flush) begin
                a_q.push_back(b);
                done = 1'b1;
            end
            tick();
        end
        if (!done) chk("a_offer_timeout", 256'd0, 256'd1);
    endtask

    task automatic a_drain();
        a_in_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (a_q.size() == 0 && !a_out_valid) break;
        end
        chk("a_drain_left", 256'(a_q.size()), 256'd0);
        tick();
    endtask

    task automatic b_drain();
        b_in_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (b_q.size() == 0 && !b_out_valid) break;
        end
        chk("b_drain_left", 256'(b_q.size()), 256'd0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_q.delete();
        b_q.delete();
    endtask

    // Monitor A: every delivered beat must be the oldest expected one
    always @(negedge clk) begin
        if (rst && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_extra_beat: got pc %0h, required no beat", a_out_pc[63:0]);
            end else begin
                a_e = a_q.pop_front();
                chk("a_commit", 256'(a_out_commit), 256'(a_e.c));
                chk("a_pc", a_out_pc, a_e.pc);
                chk("a_pre_pc", a_out_pre_pc, a_e.pre);
                chk("a_instr", 256'(a_out_instr), 256'(a_e.ins));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_extra_beat: got pc %0h, required no beat", b_out_pc);
            end else begin
                b_e = b_q.pop_front();
                chk("b_commit", 256'(b_out_commit), 256'(b_e.c[0]));
                chk("b_pc", 256'(b_out_pc), 256'(b_e.pc[63:0]));
                chk("b_pre_pc", 256'(b_out_pre_pc), 256'(b_e.pre[63:0]));
                chk("b_instr", 256'(b_out_instr), 256'(b_e.ins[31:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b0, b1, b2, b3, b4, b5;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0;
        a_in_commit = '0; a_in_pre_pc = '0; a_in_instr = '0; a_in_pc = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0;
        b_in_commit = '0; b_in_pre_pc = '0; b_in_instr = '0; b_in_pc = '0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", 256'(a_out_valid), 256'd0);
        chk("rst_out_pc", a_out_pc, 256'd0);
        chk("rst_out_commit", 256'(a_out_commit), 256'd0);
        chk("rst_cnt", 256'(a_cnt), 256'd0);
        chk("rst_in_ready", 256'(a_in_ready), 256'd1);
        chk("rst_b_in_ready", 256'(b_in_ready), 256'd1);
        tick();
        rst = 1'b1;

        // Streaming, one beat per cycle, 2 committed lanes each
        a_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) chk("stream_latency_pc", 256'(a_out_pc[63:0]), 256'(64'h8000_0000 + 64'(8 * (k - 1))));
            a_offer(mk(k, 4'b0011));
        end
        a_drain();
        chk("stream_cnt", 256'(a_cnt), 256'd16);

        // Back-pressure: two beats absorbed, third waits
        do_reset();
        a_out_ready = 1'b0;
        b0 = mk(10, 4'b0001); b1 = mk(11, 4'b0001); b2 = mk(12, 4'b0001);
        a_drive(b0);
        @(negedge clk); chk("bp_ready_empty", 256'(a_in_ready), 256'd1);
        a_q.push_back(b0); tick();
        a_drive(b1);
        @(negedge clk); chk("bp_ready_one", 256'(a_in_ready), 256'd1);
        a_q.push_back(b1); tick();
        a_drive(b2);
        @(negedge clk); chk("bp_ready_full", 256'(a_in_ready), 256'd0);
        chk("bp_hold_pc", a_out_pc, b0.pc);
        tick();
        @(negedge clk); chk("bp_ready_full2", 256'(a_in_ready), 256'd0);
        chk("bp_hold_pc2", a_out_pc, b0.pc);
        tick();
        a_out_ready = 1'b1;
        a_offer(b2);
        a_drain();
        chk("bp_cnt", 256'(a_cnt), 256'd3);

        // Flush while FULL with a deliver in the same cycle
        a_out_ready = 1'b0;
        b3 = mk(20, 4'b0111); b4 = mk(21, 4'b1111); b5 = mk(22, 4'b0001);
        a_drive(b3); a_q.push_back(b3); tick();
        a_drive(b4); a_q.push_back(b4); tick();
        a_drive(b5); a_flush = 1'b1; a_out_ready = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 256'(a_out_valid), 256'd0);
        chk("flush_out_commit", 256'(a_out_commit), 256'd0);
        chk("flush_in_ready", 256'(a_in_ready), 256'd1);
        chk("flush_cnt", 256'(a_cnt), 256'd6);
        tick();
        a_out_ready = 1'b1;
        a_drain();
        chk("flush_cnt_after", 256'(a_cnt), 256'd6);

        // Bubbles are forwarded like any other beat
        do_reset();
        a_out_ready = 1'b1;
        a_offer(mk(30, 4'b0000));
        a_offer(mk(31, 4'b0101));
        a_offer(mk(32, 4'b1111));
        a_drain();
        chk("bubble_cnt", 256'(a_cnt), 256'd6);

        // Reset while FULL, with a handshake offered during reset
        a_out_ready = 1'b0;
        a_drive(mk(33, 4'b0001)); a_q.push_back(mk(33, 4'b0001)); tick();
        a_drive(mk(34, 4'b0001)); a_q.push_back(mk(34, 4'b0001)); tick();
        rst = 1'b0;
        a_drive(mk(35, 4'b0001)); a_out_ready = 1'b1;
        tick();
        rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_q.delete();
        @(negedge clk);
        chk("rstmid_out_valid", 256'(a_out_valid), 256'd0);
        chk("rstmid_out_pc", a_out_pc, 256'd0);
        chk("rstmid_cnt", 256'(a_cnt), 256'd0);
        chk("rstmid_in_ready", 256'(a_in_ready), 256'd1);
        tick();

        // Counter wrap from all-ones
        force dut_a.r_commit_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut_a.r_commit_cnt;
        #1;
        chk("wrap_preset", 256'(a_cnt), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        a_out_ready = 1'b1;
        a_offer(mk(40, 4'b0001));
        a_drain();
        chk("wrap_cnt", 256'(a_cnt), 256'd0);

        // Pass-through stage: ready follows !out_valid | out_ready
        b0 = mk(50, 4'b0001); b1 = mk(51, 4'b0001); b2 = mk(52, 4'b0001);
        b_out_ready = 1'b1;
        b_drive(b0);
        @(negedge clk); chk("s0_ready_empty", 256'(b_in_ready), 256'd1);
        b_q.push_back(b0); tick();
        b_drive(b1);
        chk("s0_ready_comb_hi", 256'(b_in_ready), 256'd1);
        b_out_ready = 1'b0;
        #1;
        chk("s0_ready_comb_lo", 256'(b_in_ready), 256'd0);
        @(negedge clk); chk("s0_hold_valid", 256'(b_out_valid), 256'd1);
        tick();
        b_out_ready = 1'b1;
        @(negedge clk); chk("s0_ready_release", 256'(b_in_ready), 256'd1);
        b_q.push_back(b1); tick();
        b_drive(b2);
        @(negedge clk); chk("s0_ready_stream", 256'(b_in_ready), 256'd1);
        b_q.push_back(b2); tick();
        b_drain();
        chk("s0_cnt", 256'(b_cnt), 256'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
